eth_header_rx: RTL and testbench

- Strips and checks the 14-byte Ethernet II MAC header from the receive stream.
- Input is the post-preamble/SFD N-bit stream from the RMII front end.
- Filters frames on destination MAC and decodes ethertype to a 1-bit IPv4/ARP select.
- Forwards only the payload beats, with the select, to the network-layer demux (network_rx).

---
 rtl/eth_header_rx.sv | 80 ++++++++
 tb/tb_eth_header_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/eth_header_rx.sv
// eth_header_rx: strips the 14-byte Ethernet II header, filters on destination MAC and forwards payload beats.
module eth_header_rx #(
  parameter int          N        = 2,
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         ethertype,
  output logic [47:0]  src_mac,
  output logic         frame_drop
);
  localparam logic [7:0] BPB_M = 8'(8 / N - 1);
  localparam logic [7:0] HB_M  = 8'(112 / N - 1);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;
  state_t        state;
  logic [7:0]    cnt, idx, byte_sr, cur_byte;
  logic [103:0]  hdr;
  logic [111:0]  full;
  logic          byte_done, last, dest_ok, type_ok;
  // full is the header as it would look with the current beat included
  always_comb begin
    cur_byte  = 8'({axiid, byte_sr} >> N);
    idx       = state == IDLE ? 8'd0 : cnt;
    byte_done = (idx & BPB_M) == BPB_M;
    last      = idx == HB_M;
    full      = {hdr, cur_byte};
    dest_ok   = full[111:64] == MAC_ADDR || &full[111:64];
    type_ok   = full[15:0] == 16'h0800 || full[15:0] == 16'h0806;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      byte_sr    <= '0;
      hdr        <= '0;
      axiov      <= 1'b0;
      axiod      <= '0;
      ethertype  <= 1'b0;
      src_mac    <= '0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      axiov      <= 1'b0;
      axiod      <= '0;
      if ((state == IDLE || state == HEADER) && axiiv) begin
        byte_sr <= cur_byte;
        cnt     <= idx + 8'd1;
        if (byte_done) hdr <= {hdr[95:0], cur_byte};
      end
      case (state)
        IDLE: if (axiiv) state <= HEADER;
        HEADER:
          if (!axiiv) begin
            state      <= IDLE;
            frame_drop <= 1'b1;
          end else if (last) begin
            if (dest_ok && type_ok) begin
              state     <= PAYLOAD;
              ethertype <= full[1];
              src_mac   <= full[63:16];
            end else begin
              state      <= DROP;
              frame_drop <= 1'b1;
            end
          end
        PAYLOAD: begin
          axiov <= axiiv;
          axiod <= axiiv ? axiid : '0;
          if (!axiiv) state <= IDLE;
        end
        DROP: if (!axiiv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_header_rx.sv
// tb_eth_header_rx: frame-level model of header filtering compared against the DUT every cycle.
module tb_eth_header_rx;
  localparam int N = 2;
  localparam int BPB = 8 / N;
  localparam int HB = 112 / N;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;
  logic clk = 0, rst = 1, axiiv = 0;
  logic [N-1:0] axiid = '0;
  logic axiov, ethertype, frame_drop;
  logic [N-1:0] axiod;
  logic [47:0] src_mac;
  eth_header_rx #(.N(N), .MAC_ADDR(MAC)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(axiov), .axiod(axiod),
    .ethertype(ethertype), .src_mac(src_mac), .frame_drop(frame_drop)
  );
  always #5 clk = ~clk;
  typedef struct {logic v; logic [N-1:0] d; logic et; logic [47:0] src; logic drop;} exp_t;
  exp_t q[$];
  exp_t ce;
  logic [7:0] fr[$];
  logic [N-1:0] cap[$];
  int n_chk = 0, n_fail = 0, drops = 0;
  logic m_et = 0;
  logic [47:0] m_src = '0;
  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // outputs after each edge are checked against the expectation queued for that edge
  always @(posedge clk) begin
    #1;
    if (axiov) cap.push_back(axiod);
    if (frame_drop) drops++;
    if (q.size() > 0) begin
      ce = q.pop_front();
      chk("axiov", 48'(axiov), 48'(ce.v));
      chk("axiod", 48'(axiod), 48'(ce.d));
      chk("frame_drop", 48'(frame_drop), 48'(ce.drop));
      chk("ethertype", 48'(ethertype), 48'(ce.et));
      chk("src_mac", src_mac, ce.src);
    end
  end
  task automatic build(input logic [47:0] dst, input logic [47:0] s, input logic [15:0] ty,
                       input int plen, input logic [7:0] p0, input logic [7:0] p1);
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(8'(dst >> (8 * (5 - i))));
    for (int i = 0; i < 6; i++) fr.push_back(8'(s >> (8 * (5 - i))));
    fr.push_back(ty[15:8]);
    fr.push_back(ty[7:0]);
    for (int i = 0; i < plen; i++) fr.push_back(i == 0 ? p0 : i == 1 ? p1 : 8'(i * 37 + 11));
  endtask
  task automatic send(input int nb_in, input int idle);
    int nb;
    logic [47:0] dst, s;
    logic [15:0] ty;
    logic complete, acc;
    logic [N-1:0] bt;
    exp_t e;
    nb = nb_in < 0 ? fr.size() * BPB : nb_in;
    for (int i = 0; i < 6; i++) begin
      dst = {dst[39:0], fr[i]};
      s = {s[39:0], fr[i + 6]};
    end
    ty = {fr[12], fr[13]};
    complete = nb >= HB;
    acc = complete && (dst == MAC || dst == BC) && (ty == 16'h0800 || ty == 16'h0806);
    for (int i = 0; i < nb; i++) begin
      bt = N'(fr[i / BPB] >> (N * (i % BPB)));
      @(negedge clk);
      axiiv = 1;
      axiid = bt;
      if (i == HB - 1 && acc) begin
        m_et = ty == 16'h0806;
        m_src = s;
      end
      e.v = acc && i >= HB;
      e.d = e.v ? bt : '0;
      e.drop = i == HB - 1 && !acc;
      e.et = m_et;
      e.src = m_src;
      q.push_back(e);
    end
    for (int j = 0; j < idle; j++) begin
      @(negedge clk);
      axiiv = 0;
      axiid = '0;
      e.v = 0;
      e.d = '0;
      e.drop = j == 0 && nb > 0 && !complete;
      e.et = m_et;
      e.src = m_src;
      q.push_back(e);
    end
  endtask
  task automatic drain;
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 48'(q.size()), 48'd0);
  endtask
  logic [N-1:0] ipv4_lit [8] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  initial begin
    #1;
    chk("rst_axiov", 48'(axiov), 48'd0);
    chk("rst_axiod", 48'(axiod), 48'd0);
    chk("rst_ethertype", 48'(ethertype), 48'd0);
    chk("rst_src_mac", src_mac, 48'd0);
    chk("rst_frame_drop", 48'(frame_drop), 48'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    // broadcast ARP, 28-byte payload
    build(BC, 48'h112233445566, 16'h0806, 28, 8'h00, 8'h01);
    cap.delete(); drops = 0;
    send(-1, 2); drain;
    chk("arp_beats", 48'(cap.size()), 48'd112);
    chk("arp_ethertype", 48'(ethertype), 48'd1);
    chk("arp_src", src_mac, 48'h112233445566);
    chk("arp_drops", 48'(drops), 48'd0);
    // unicast IPv4 starting 0x45,0x00
    build(MAC, 48'hAABBCCDDEEFF, 16'h0800, 8, 8'h45, 8'h00);
    cap.delete(); drops = 0;
    send(-1, 1); drain;
    chk("ipv4_beats", 48'(cap.size()), 48'd32);
    if (cap.size() >= 8)
      for (int i = 0; i < 8; i++) chk("ipv4_first_beats", 48'(cap[i]), 48'(ipv4_lit[i]));
    chk("ipv4_ethertype", 48'(ethertype), 48'd0);
    chk("ipv4_src", src_mac, 48'hAABBCCDDEEFF);
    // wrong destination
    build(48'h02_00_00_00_00_02, 48'h999999999999, 16'h0800, 8, 8'h45, 8'h00);
    cap.delete(); drops = 0;
    send(-1, 1); drain;
    chk("wrongdst_beats", 48'(cap.size()), 48'd0);
    chk("wrongdst_drops", 48'(drops), 48'd1);
    chk("wrongdst_src_kept", src_mac, 48'hAABBCCDDEEFF);
    // IPv6 ethertype
    build(MAC, 48'h888888888888, 16'h86DD, 8, 8'h60, 8'h00);
    cap.delete(); drops = 0;
    send(-1, 1); drain;
    chk("ipv6_beats", 48'(cap.size()), 48'd0);
    chk("ipv6_drops", 48'(drops), 48'd1);
    chk("ipv6_et_kept", 48'(ethertype), 48'd0);
    // runt of 30 beats, then valid ARP after a single idle cycle
    build(MAC, 48'h010203040506, 16'h0806, 28, 8'h00, 8'h01);
    cap.delete(); drops = 0;
    send(30, 1);
    send(-1, 2); drain;
    chk("runt_drops", 48'(drops), 48'd1);
    chk("after_runt_beats", 48'(cap.size()), 48'd112);
    chk("after_runt_et", 48'(ethertype), 48'd1);
    chk("after_runt_src", src_mac, 48'h010203040506);
    // async reset mid-payload
    build(MAC, 48'h0A0B0C0D0E0F, 16'h0800, 20, 8'h45, 8'h00);
    send(HB + 20, 0);
    @(posedge clk); #2;
    chk("pre_rst_axiov", 48'(axiov), 48'd1);
    axiiv = 0; axiid = '0; rst = 1;
    #1;
    chk("mid_rst_axiov", 48'(axiov), 48'd0);
    chk("mid_rst_axiod", 48'(axiod), 48'd0);
    chk("mid_rst_ethertype", 48'(ethertype), 48'd0);
    chk("mid_rst_src", src_mac, 48'd0);
    chk("mid_rst_drop", 48'(frame_drop), 48'd0);
    m_et = 0; m_src = '0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    build(BC, 48'h0A0B0C0D0E0F, 16'h0800, 10, 8'h45, 8'h00);
    cap.delete(); drops = 0;
    send(-1, 2); drain;
    chk("post_rst_beats", 48'(cap.size()), 48'd40);
    chk("post_rst_et", 48'(ethertype), 48'd0);
    chk("post_rst_src", src_mac, 48'h0A0B0C0D0E0F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
